// File: rtl/dumper_bus_pkg.sv
// Shared definitions for the dumper cartridge bus: arbiter state encoding and
// requester identifiers used by the round-robin tie breaker.
package dumper_bus_pkg;

  localparam int unsigned STATE_W = 3;

  // Arbiter states; encoding fixed so debug probes read the same across builds.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_PRG_ALIGN  = 3'd1,
    ST_PRG_LOW    = 3'd2,
    ST_PRG_HIGH   = 3'd3,
    ST_CHR_SETUP  = 3'd4,
    ST_CHR_STROBE = 3'd5,
    ST_CHR_HOLD   = 3'd6
  } arb_state_e;

  // Requester identifiers, stored in the last_grant flag.
  localparam logic REQ_PRG = 1'b0;
  localparam logic REQ_CHR = 1'b1;

endpackage : dumper_bus_pkg

// File: rtl/m2_clock_gen.sv
// Free-running M2 generator. m2 toggles every M2_HALF_PERIOD master clocks and
// never stops. m2_rise / m2_fall are decoded from the current state and are
// high during the clock whose closing edge changes m2, so a consumer can act
// on the very edge where m2 moves.
//   master_clock  in   sole clock, rising edge
//   reset         in   asynchronous, active-high
//   m2            out  generated CPU clock (registered)
//   m2_rise       out  next edge drives m2 high
//   m2_fall       out  next edge drives m2 low
module m2_clock_gen #(
  parameter int unsigned M2_HALF_PERIOD = 9
) (
  input  logic master_clock,
  input  logic reset,
  output logic m2,
  output logic m2_rise,
  output logic m2_fall
);

  localparam int unsigned CNT_W = $clog2(M2_HALF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(M2_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max  = (cnt == CNT_MAX);
  assign m2_rise = at_max & ~m2;
  assign m2_fall = at_max & m2;

  // Half-phase counter; m2 flips on each wrap.
  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      m2  <= 1'b0;
    end else if (at_max) begin
      cnt <= '0;
      m2  <= ~m2;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule : m2_clock_gen

// File: rtl/cart_bus_arbiter.sv
// Cartridge bus sequencer for the dumper CPLD. Shares one host data path between
// CPU-space (PRG) and PPU-space (CHR) requesters, one cartridge cycle at a time.
// PRG cycles are aligned to the free-running M2; CHR cycles use a fixed strobe
// timer. Completion is a one-clock ack pulse per requester.
//   master_clock, reset           clock and async active-high reset
//   prg_req/prg_write/prg_a15     PRG request level, direction and A15 (sampled at grant)
//   prg_ack                       PRG completion pulse
//   chr_req/chr_write             CHR request level and direction (sampled at grant)
//   chr_ack                       CHR completion pulse
//   m2, romsel, cpu_rw, cpu_oe    CPU-side bus signals (romsel, cpu_oe active low)
//   ppu_rd, ppu_wr                PPU-side strobes, active low
//   busy                          high whenever a cycle is in flight
// M2_HALF_PERIOD must be >= 2 and CHR_STROBE_CYCLES >= 1.
module cart_bus_arbiter
  import dumper_bus_pkg::*;
#(
  parameter int unsigned M2_HALF_PERIOD    = 9,
  parameter int unsigned CHR_STROBE_CYCLES = 4
) (
  input  logic master_clock,
  input  logic reset,
  input  logic prg_req,
  input  logic prg_write,
  input  logic prg_a15,
  output logic prg_ack,
  input  logic chr_req,
  input  logic chr_write,
  output logic chr_ack,
  output logic m2,
  output logic romsel,
  output logic cpu_rw,
  output logic cpu_oe,
  output logic ppu_rd,
  output logic ppu_wr,
  output logic busy
);

  localparam int unsigned      SCNT_W    = $clog2(CHR_STROBE_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(CHR_STROBE_CYCLES);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

  logic m2_rise;
  logic m2_fall;

  m2_clock_gen #(
    .M2_HALF_PERIOD(M2_HALF_PERIOD)
  ) u_m2_clock_gen (
    .master_clock(master_clock),
    .reset       (reset),
    .m2          (m2),
    .m2_rise     (m2_rise),
    .m2_fall     (m2_fall)
  );

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic              a15_q, a15_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              romsel_d, cpu_rw_d, cpu_oe_d, ppu_rd_d, ppu_wr_d;
  logic              prg_ack_d, chr_ack_d, busy_d;

  logic              pick_prg;
  logic              pick_chr;
  logic              tie;

  // On a tie, PRG wins unless it won the previous contested grant.
  assign tie      = prg_req & chr_req;
  assign pick_prg = prg_req & (~chr_req | (last_grant_q == REQ_CHR));
  assign pick_chr = chr_req & ~pick_prg;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    a15_d        = a15_q;
    scnt_d       = scnt_q;
    romsel_d     = romsel;
    cpu_rw_d     = cpu_rw;
    cpu_oe_d     = cpu_oe;
    ppu_rd_d     = ppu_rd;
    ppu_wr_d     = ppu_wr;
    prg_ack_d    = 1'b0;
    chr_ack_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // last_grant only records contested grants, so repeated ties alternate.
        if (tie) begin
          last_grant_d = pick_prg ? REQ_PRG : REQ_CHR;
        end
        if (pick_prg) begin
          write_d = prg_write;
          a15_d   = prg_a15;
          if (m2_fall) begin
            // Grant coincides with a fall: skip alignment.
            state_d  = ST_PRG_LOW;
            cpu_oe_d = 1'b0;
            cpu_rw_d = ~prg_write;
          end else begin
            state_d = ST_PRG_ALIGN;
          end
        end else if (pick_chr) begin
          write_d = chr_write;
          state_d = ST_CHR_SETUP;
        end
      end

      ST_PRG_ALIGN: begin
        if (m2_fall) begin
          state_d  = ST_PRG_LOW;
          cpu_oe_d = 1'b0;
          cpu_rw_d = ~write_q;
        end
      end

      ST_PRG_LOW: begin
        if (m2_rise) begin
          state_d  = ST_PRG_HIGH;
          romsel_d = ~a15_q;
        end
      end

      ST_PRG_HIGH: begin
        if (m2_fall) begin
          state_d   = ST_IDLE;
          romsel_d  = 1'b1;
          cpu_oe_d  = 1'b1;
          cpu_rw_d  = 1'b1;
          prg_ack_d = 1'b1;
        end
      end

      ST_CHR_SETUP: begin
        state_d = ST_CHR_STROBE;
        scnt_d  = SCNT_LOAD;
        if (write_q) begin
          ppu_wr_d = 1'b0;
        end else begin
          ppu_rd_d = 1'b0;
        end
      end

      ST_CHR_STROBE: begin
        // Counter was loaded on entry; the last strobe clock sees it at one.
        if (scnt_q == SCNT_ONE) begin
          state_d  = ST_CHR_HOLD;
          ppu_rd_d = 1'b1;
          ppu_wr_d = 1'b1;
        end else begin
          scnt_d = scnt_q - SCNT_ONE;
        end
      end

      ST_CHR_HOLD: begin
        state_d   = ST_IDLE;
        chr_ack_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_CHR;
      write_q      <= 1'b0;
      a15_q        <= 1'b0;
      scnt_q       <= '0;
      romsel       <= 1'b1;
      cpu_rw       <= 1'b1;
      cpu_oe       <= 1'b1;
      ppu_rd       <= 1'b1;
      ppu_wr       <= 1'b1;
      prg_ack      <= 1'b0;
      chr_ack      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      a15_q        <= a15_d;
      scnt_q       <= scnt_d;
      romsel       <= romsel_d;
      cpu_rw       <= cpu_rw_d;
      cpu_oe       <= cpu_oe_d;
      ppu_rd       <= ppu_rd_d;
      ppu_wr       <= ppu_wr_d;
      prg_ack      <= prg_ack_d;
      chr_ack      <= chr_ack_d;
      busy         <= busy_d;
    end
  end

endmodule : cart_bus_arbiter

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter. Edges are numbered from reset release; M2 phase
// and ack edges are predicted arithmetically and queued as expectations.
module tb_cart_bus_arbiter;

  localparam int unsigned H      = 9;
  localparam int unsigned N      = 4;
  localparam int unsigned FALL_P = 2 * H;

  logic master_clock = 1'b0;
  logic reset        = 1'b1;
  logic prg_req      = 1'b0;
  logic prg_write    = 1'b0;
  logic prg_a15      = 1'b0;
  logic chr_req      = 1'b0;
  logic chr_write    = 1'b0;
  logic prg_ack, chr_ack, m2, romsel, cpu_rw, cpu_oe, ppu_rd, ppu_wr, busy;

  typedef struct {
    bit          is_chr;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int unsigned k;
  int          total = 0;
  int          bad   = 0;

  cart_bus_arbiter #(
    .M2_HALF_PERIOD   (H),
    .CHR_STROBE_CYCLES(N)
  ) dut (
    .master_clock(master_clock),
    .reset       (reset),
    .prg_req     (prg_req),
    .prg_write   (prg_write),
    .prg_a15     (prg_a15),
    .prg_ack     (prg_ack),
    .chr_req     (chr_req),
    .chr_write   (chr_write),
    .chr_ack     (chr_ack),
    .m2          (m2),
    .romsel      (romsel),
    .cpu_rw      (cpu_rw),
    .cpu_oe      (cpu_oe),
    .ppu_rd      (ppu_rd),
    .ppu_wr      (ppu_wr),
    .busy        (busy)
  );

  always #5 master_clock = ~master_clock;

  task automatic tick();
    @(posedge master_clock);
    k++;
    #1;
  endtask

  // First m2 fall edge at or after edge g (falls land on multiples of 2H).
  function automatic int unsigned next_fall(input int unsigned g);
    int unsigned f;
    f = ((g + FALL_P - 1) / FALL_P) * FALL_P;
    if (f == 0) f = FALL_P;
    return f;
  endfunction

  function automatic logic model_m2(input int unsigned e);
    return 1'((e / H) % 2);
  endfunction

  task automatic test_reset();
    logic [8:0]  outs;
    int unsigned hi_cnt, first_rise, idle_bad;
    reset = 1'b1;
    repeat (3) tick();
    outs = {m2, romsel, cpu_rw, cpu_oe, ppu_rd, ppu_wr, prg_ack, chr_ack, busy};
    total++;
    if (outs !== 9'b011111000) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b", outs, 9'b011111000);
    end
    reset = 1'b0;
    k = 0;
    hi_cnt = 0; first_rise = 0; idle_bad = 0;
    for (int i = 0; i < 4 * H; i++) begin
      tick();
      total++;
      if (m2 !== model_m2(k)) begin
        bad++;
        $display("FAIL m2_phase edge=%0d got=%b exp=%b", k, m2, model_m2(k));
      end
      if (m2 === 1'b1) begin
        hi_cnt++;
        if (first_rise == 0) first_rise = k;
      end
      if ({romsel, cpu_rw, cpu_oe, ppu_rd, ppu_wr, busy, prg_ack, chr_ack} !== 8'b11111000)
        idle_bad++;
    end
    total++;
    if (hi_cnt != 2 * H) begin
      bad++;
      $display("FAIL m2_duty high_clocks=%0d exp=%0d", hi_cnt, 2 * H);
    end
    total++;
    if (first_rise != H) begin
      bad++;
      $display("FAIL m2_first_rise edge=%0d exp=%0d", first_rise, H);
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL idle_outputs bad_clocks=%0d exp=0", idle_bad);
    end
  endtask

  task automatic test_prg_cycle(input logic wr, input logic a15, input bit after_fall);
    int unsigned g, oe_low, oe_first, rs_low, rs_bad_phase, rw_low;
    bit          got;
    exp_t        e;
    if (after_fall) begin
      for (int i = 0; i < 2 * FALL_P && (k % FALL_P) != 0; i++) tick();
      repeat (3) tick();
    end
    prg_write = wr; prg_a15 = a15; prg_req = 1'b1;
    g = k + 1;
    sb.push_back('{1'b0, next_fall(g) + FALL_P});
    oe_low = 0; oe_first = 0; rs_low = 0; rs_bad_phase = 0; rw_low = 0; got = 0;
    for (int i = 0; i < 3 * FALL_P; i++) begin
      tick();
      if (prg_ack === 1'b1 || chr_ack === 1'b1) begin
        got = 1; prg_req = 1'b0;
        break;
      end
      if (cpu_oe === 1'b0) begin
        oe_low++;
        if (oe_first == 0) oe_first = k;
      end
      if (romsel === 1'b0) begin
        rs_low++;
        if (m2 !== 1'b1) rs_bad_phase++;
      end
      if (cpu_rw === 1'b0) rw_low++;
    end
    total++;
    if (!got) begin
      bad++; prg_req = 1'b0;
      $display("FAIL prg_ack_timeout edge=%0d", k);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL prg_unexpected_ack edge=%0d", k);
    end else begin
      e = sb.pop_front();
      if (chr_ack !== e.is_chr || prg_ack === e.is_chr || k != e.edge_no) begin
        bad++;
        $display("FAIL prg_ack_edge got_edge=%0d chr=%b exp_edge=%0d chr=%b",
                 k, chr_ack, e.edge_no, e.is_chr);
      end
    end
    total++;
    if (oe_low != FALL_P || oe_first != next_fall(g)) begin
      bad++;
      $display("FAIL prg_cpu_oe low=%0d first=%0d exp low=%0d first=%0d",
               oe_low, oe_first, FALL_P, next_fall(g));
    end
    total++;
    if (rs_low != (a15 ? H : 0) || rs_bad_phase != 0) begin
      bad++;
      $display("FAIL prg_romsel low=%0d with_m2_low=%0d exp low=%0d with_m2_low=0",
               rs_low, rs_bad_phase, a15 ? H : 0);
    end
    total++;
    if (rw_low != (wr ? FALL_P : 0)) begin
      bad++;
      $display("FAIL prg_cpu_rw low=%0d exp=%0d", rw_low, wr ? FALL_P : 0);
    end
    tick();
    total++;
    if ({prg_ack, chr_ack, busy} !== 3'b000) begin
      bad++;
      $display("FAIL prg_after_ack ack_ack_busy=%b exp=000", {prg_ack, chr_ack, busy});
    end
  endtask

  task automatic test_chr_cycle(input logic wr);
    int unsigned g, wr_low, rd_low;
    bit          got;
    exp_t        e;
    chr_write = wr; chr_req = 1'b1;
    g = k + 1;
    sb.push_back('{1'b1, g + N + 2});
    wr_low = 0; rd_low = 0; got = 0;
    for (int i = 0; i < 4 * N + 10; i++) begin
      tick();
      if (prg_ack === 1'b1 || chr_ack === 1'b1) begin
        got = 1; chr_req = 1'b0;
        break;
      end
      if (ppu_wr === 1'b0) wr_low++;
      if (ppu_rd === 1'b0) rd_low++;
    end
    total++;
    if (!got) begin
      bad++; chr_req = 1'b0;
      $display("FAIL chr_ack_timeout edge=%0d", k);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL chr_unexpected_ack edge=%0d", k);
    end else begin
      e = sb.pop_front();
      if (chr_ack !== e.is_chr || prg_ack === e.is_chr || k != e.edge_no) begin
        bad++;
        $display("FAIL chr_ack_edge got_edge=%0d chr=%b exp_edge=%0d chr=%b",
                 k, chr_ack, e.edge_no, e.is_chr);
      end
    end
    total++;
    if (wr_low != (wr ? N : 0) || rd_low != (wr ? 0 : N)) begin
      bad++;
      $display("FAIL chr_strobe wr_low=%0d rd_low=%0d exp wr_low=%0d rd_low=%0d",
               wr_low, rd_low, wr ? N : 0, wr ? 0 : N);
    end
    tick();
    total++;
    if ({prg_ack, chr_ack, busy} !== 3'b000) begin
      bad++;
      $display("FAIL chr_after_ack ack_ack_busy=%b exp=000", {prg_ack, chr_ack, busy});
    end
  endtask

  task automatic test_tie(input bit prg_first, input bit from_reset);
    int unsigned g, a1, n_acks;
    exp_t        e;
    if (from_reset) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      k = 0;
      sb.delete();
    end
    prg_write = 1'b0; prg_a15 = 1'b1; chr_write = 1'b0;
    prg_req = 1'b1; chr_req = 1'b1;
    g = k + 1;
    if (prg_first) begin
      a1 = next_fall(g) + FALL_P;
      sb.push_back('{1'b0, a1});
      sb.push_back('{1'b1, a1 + 1 + N + 2});
    end else begin
      a1 = g + N + 2;
      sb.push_back('{1'b1, a1});
      sb.push_back('{1'b0, next_fall(a1 + 1) + FALL_P});
    end
    n_acks = 0;
    for (int i = 0; i < 8 * FALL_P && n_acks < 2; i++) begin
      tick();
      if (prg_ack === 1'b1 || chr_ack === 1'b1) begin
        n_acks++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL tie_unexpected_ack edge=%0d", k);
        end else begin
          e = sb.pop_front();
          if (chr_ack !== e.is_chr || prg_ack === e.is_chr || k != e.edge_no) begin
            bad++;
            $display("FAIL tie_order got_edge=%0d prg=%b chr=%b exp_edge=%0d chr=%b",
                     k, prg_ack, chr_ack, e.edge_no, e.is_chr);
          end
        end
        if (prg_ack === 1'b1) prg_req = 1'b0;
        if (chr_ack === 1'b1) chr_req = 1'b0;
      end
    end
    total++;
    if (n_acks != 2) begin
      bad++;
      $display("FAIL tie_ack_count got=%0d exp=2", n_acks);
    end
    prg_req = 1'b0; chr_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_chr();
    int unsigned wr_low, stray_ack;
    bit          got;
    exp_t        e;
    chr_write = 1'b1; chr_req = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ppu_wr === 1'b0) begin
        got = 1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL midreset_no_strobe edge=%0d", k);
    end
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ppu_wr, ppu_rd, busy, chr_ack, m2} !== 5'b11000) begin
      bad++;
      $display("FAIL midreset_async wr_rd_busy_ack_m2=%b exp=11000",
               {ppu_wr, ppu_rd, busy, chr_ack, m2});
    end
    stray_ack = 0;
    repeat (2) begin
      tick();
      if (chr_ack !== 1'b0 || prg_ack !== 1'b0) stray_ack++;
    end
    reset = 1'b0;
    k = 0;
    sb.delete();
    sb.push_back('{1'b1, 1 + N + 2});
    wr_low = 0; got = 0;
    for (int i = 0; i < 4 * N + 10; i++) begin
      tick();
      if (prg_ack === 1'b1 || chr_ack === 1'b1) begin
        got = 1; chr_req = 1'b0;
        break;
      end
      if (ppu_wr === 1'b0) wr_low++;
    end
    total++;
    if (stray_ack != 0) begin
      bad++;
      $display("FAIL midreset_stray_ack clocks=%0d exp=0", stray_ack);
    end
    total++;
    if (!got) begin
      bad++; chr_req = 1'b0;
      $display("FAIL midreset_ack_timeout edge=%0d", k);
    end else begin
      e = sb.pop_front();
      if (chr_ack !== e.is_chr || k != e.edge_no || wr_low != N) begin
        bad++;
        $display("FAIL midreset_fresh_cycle edge=%0d wr_low=%0d exp edge=%0d wr_low=%0d",
                 k, wr_low, e.edge_no, N);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    k = 0;
    test_reset();
    test_prg_cycle(1'b0, 1'b1, 1'b1);
    test_prg_cycle(1'b1, 1'b0, 1'b0);
    test_chr_cycle(1'b1);
    test_chr_cycle(1'b0);
    test_tie(1'b1, 1'b1);
    test_tie(1'b0, 1'b0);
    test_reset_mid_chr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cart_bus_arbiter
